// File: rtl/video_pkg.sv
// Shared video types and default geometry for the frame-buffer writer path.
package video_pkg;

    typedef logic [15:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } fbw_state_t;

    localparam int unsigned DEF_H_ACTIVE = 320;
    localparam int unsigned DEF_V_ACTIVE = 180;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_xy_counter.sv
// Raster x/y position of the next incoming pixel, with last-pixel and
// decimation-keep flags derived from the current position.
module fb_xy_counter
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter bit          DECIMATE = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_restart,
    input  logic i_en,
    output logic o_last,
    output logic o_keep
);

    localparam int unsigned XW = cnt_w(H_ACTIVE);
    localparam int unsigned YW = cnt_w(V_ACTIVE);
    localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    // Restart loads the successor of the origin, since the origin pixel is
    // consumed in the same cycle the restart is seen.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_restart) begin
            if (H_ACTIVE == 1) begin
                r_x <= '0;
                r_y <= YW'(1);
            end else begin
                r_x <= XW'(1);
                r_y <= '0;
            end
        end else if (i_en) begin
            if (r_x == X_MAX) begin
                r_x <= '0;
                r_y <= r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    assign o_last = (r_x == X_MAX) && (r_y == Y_MAX);
    assign o_keep = DECIMATE ? (~r_x[0] & ~r_y[0]) : 1'b1;

endmodule

// File: rtl/video_fb_writer.sv
// Pixel-stream to linear BRAM write converter; captures one frame per arm.
// Define VIDEO_FB_WRITER_DOWNSAMPLE_EN for 2x decimation in both axes.
module video_fb_writer
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [15:0]       pixel_in,
    input  logic              valid_in,
    input  logic              sof_in,
    input  logic              arm_in,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [15:0]       wr_data_out,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic              short_frame_out,
    output logic              long_frame_out
);

`ifdef VIDEO_FB_WRITER_DOWNSAMPLE_EN
    localparam bit DECIMATE = 1'b1;
`else
    localparam bit DECIMATE = 1'b0;
`endif

    localparam bit ORIGIN_LAST = (H_ACTIVE == 1) && (V_ACTIVE == 1);

    fbw_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    pixel_t            w_pixel;
    logic              w_accept;
    logic              w_restart;
    logic              w_last;
    logic              w_keep;
    logic              w_write;
    logic              w_done;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_cnt_last;
    logic              w_cnt_keep;

    // A sof beat is the origin pixel regardless of where the counters are.
    always_comb begin
        w_pixel   = pixel_in;
        w_accept  = valid_in && (((r_state == ARMED) && arm_in && sof_in) ||
                                 (r_state == CAPTURE));
        w_restart = w_accept && sof_in;
        w_last    = w_restart ? ORIGIN_LAST : w_cnt_last;
        w_keep    = w_restart ? 1'b1 : w_cnt_keep;
        w_write   = w_accept && w_keep;
        w_done    = w_accept && w_last;
        w_wr_addr = w_restart ? '0 : r_addr;
    end

    fb_xy_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .DECIMATE (DECIMATE)
    ) u_xy (
        .i_clk     (clk_in),
        .i_rst     (rst_in),
        .i_clr     (w_done),
        .i_restart (w_restart && !w_last),
        .i_en      (w_accept && !w_restart && !w_last),
        .o_last    (w_cnt_last),
        .o_keep    (w_cnt_keep)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            wr_en_out       <= 1'b0;
            wr_addr_out     <= '0;
            wr_data_out     <= '0;
            busy_out        <= 1'b0;
            frame_done_out  <= 1'b0;
            short_frame_out <= 1'b0;
        end else begin
            wr_en_out      <= w_write;
            frame_done_out <= w_done;
            if (w_write) begin
                wr_addr_out <= w_wr_addr;
                wr_data_out <= w_pixel;
            end

            if (w_done) begin
                r_addr <= '0;
            end else if (w_write) begin
                r_addr <= w_wr_addr + ADDR_W'(1);
            end

            if ((r_state == CAPTURE) && w_restart) begin
                short_frame_out <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (arm_in) begin
                        r_state  <= ARMED;
                        busy_out <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!arm_in) begin
                        r_state  <= IDLE;
                        busy_out <= 1'b0;
                    end else if (w_accept && !w_done) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (w_done) begin
                        r_state  <= arm_in ? ARMED : IDLE;
                        busy_out <= arm_in;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

    assign long_frame_out = 1'b0;

endmodule

// File: tb/tb_video_fb_writer.sv
// Scoreboard bench for video_fb_writer on a reduced 8x4 geometry.
module tb_video_fb_writer;
    import video_pkg::*;

    localparam int unsigned H  = 8;
    localparam int unsigned V  = 4;
    localparam int unsigned N  = H * V;
    localparam int unsigned AW = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        pixel_t        data;
        logic          done;
    } exp_t;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [15:0]   pixel_in = '0;
    logic          valid_in = 1'b0;
    logic          sof_in = 1'b0;
    logic          arm_in = 1'b0;
    logic          wr_en_out;
    logic [AW-1:0] wr_addr_out;
    logic [15:0]   wr_data_out;
    logic          busy_out;
    logic          frame_done_out;
    logic          short_frame_out;
    logic          long_frame_out;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    video_fb_writer #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .pixel_in        (pixel_in),
        .valid_in        (valid_in),
        .sof_in          (sof_in),
        .arm_in          (arm_in),
        .wr_en_out       (wr_en_out),
        .wr_addr_out     (wr_addr_out),
        .wr_data_out     (wr_data_out),
        .busy_out        (busy_out),
        .frame_done_out  (frame_done_out),
        .short_frame_out (short_frame_out),
        .long_frame_out  (long_frame_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic v, input logic s, input logic [15:0] p);
        valid_in = v;
        sof_in   = s;
        pixel_in = p;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        sof_in   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) beat(1'b0, 1'b0, 16'h0000);
    endtask

    // Expected BRAM traffic for raster index i of a frame.
    task automatic exp_pixel(input int unsigned i, input logic [15:0] d);
        exp_t        e;
        int unsigned x;
        int unsigned y;
        x = i % H;
        y = i / H;
`ifdef VIDEO_FB_WRITER_DOWNSAMPLE_EN
        e.we   = ((x % 2) == 0) && ((y % 2) == 0);
        e.addr = AW'((y / 2) * (H / 2) + x / 2);
`else
        e.we   = 1'b1;
        e.addr = AW'(i);
`endif
        e.data = d;
        e.done = (i == N - 1);
        if (e.we || e.done) q.push_back(e);
    endtask

    // Monitor: every write or done pulse must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (!rst_in && (wr_en_out || frame_done_out)) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: got we=%0b addr=%0d data=%h done=%0b, expected no output",
                             wr_en_out, wr_addr_out, wr_data_out, frame_done_out);
                end else begin
                    e = q.pop_front();
                    if (e.we !== wr_en_out || e.done !== frame_done_out ||
                        (e.we && (e.addr !== wr_addr_out || e.data !== wr_data_out))) begin
                        n_bad++;
                        $display("FAIL write: got we=%0b addr=%0d data=%h done=%0b, expected we=%0b addr=%0d data=%h done=%0b",
                                 wr_en_out, wr_addr_out, wr_data_out, frame_done_out,
                                 e.we, e.addr, e.data, e.done);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(3);
        chk("rst_wr_en", 32'(wr_en_out), 0);
        chk("rst_wr_addr", 32'(wr_addr_out), 0);
        chk("rst_wr_data", 32'(wr_data_out), 0);
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_done", 32'(frame_done_out), 0);
        chk("rst_short", 32'(short_frame_out), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        idle(2);

        // Armed, continuous full frame, pixel = index
        arm_in = 1'b1;
        idle(1);
        chk("armed_busy", 32'(busy_out), 1);
        for (int unsigned i = 0; i < N; i++) begin
            exp_pixel(i, 16'h1000 + 16'(i));
            beat(1'b1, i == 0, 16'h1000 + 16'(i));
        end
        idle(2);
        chk("rearmed_busy", 32'(busy_out), 1);
        chk("frame1_drained", 32'(q.size()), 0);

        // Non-sof pixels ignored while armed, then gapped frame
        for (int k = 0; k < 10; k++) beat(1'b1, 1'b0, 16'hBAD0 + 16'(k));
        chk("pre_sof_busy", 32'(busy_out), 1);
        for (int unsigned i = 0; i < N; i++) begin
            exp_pixel(i, 16'h2000 + 16'(i));
            beat(1'b1, i == 0, 16'h2000 + 16'(i));
            beat(1'b0, 1'b0, 16'hFFFF);
        end
        idle(2);
        chk("frame2_drained", 32'(q.size()), 0);
        chk("no_short_yet", 32'(short_frame_out), 0);

        // Short frame: sof reinjected after 12 pixels; arm dropped mid-capture
        for (int unsigned i = 0; i < 12; i++) begin
            exp_pixel(i, 16'h3000 + 16'(i));
            beat(1'b1, i == 0, 16'h3000 + 16'(i));
        end
        exp_pixel(0, 16'h4000);
        beat(1'b1, 1'b1, 16'h4000);
        chk("short_set", 32'(short_frame_out), 1);
        arm_in = 1'b0;
        for (int unsigned i = 1; i < N; i++) begin
            exp_pixel(i, 16'h4000 + 16'(i));
            beat(1'b1, 1'b0, 16'h4000 + 16'(i));
        end
        idle(2);
        chk("idle_after_done", 32'(busy_out), 0);
        chk("short_sticky", 32'(short_frame_out), 1);
        chk("frame3_drained", 32'(q.size()), 0);

        // Unarmed frame produces nothing
        for (int unsigned i = 0; i < H; i++) beat(1'b1, i == 0, 16'h6000 + 16'(i));
        idle(2);

        // Reset mid-capture: write of pixel 4 is dropped
        arm_in = 1'b1;
        idle(1);
        for (int unsigned i = 0; i < 5; i++) begin
            if (i < 4) exp_pixel(i, 16'h5000 + 16'(i));
            beat(1'b1, i == 0, 16'h5000 + 16'(i));
        end
        rst_in = 1'b1;
        #1;
        chk("midrst_wr_en", 32'(wr_en_out), 0);
        chk("midrst_addr", 32'(wr_addr_out), 0);
        chk("midrst_data", 32'(wr_data_out), 0);
        chk("midrst_busy", 32'(busy_out), 0);
        chk("midrst_short", 32'(short_frame_out), 0);
        arm_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        idle(1);
        for (int unsigned i = 0; i < H; i++) beat(1'b1, i == 0, 16'h7000 + 16'(i));
        idle(3);
        chk("post_rst_busy", 32'(busy_out), 0);
        chk("final_drained", 32'(q.size()), 0);
        chk("long_frame", 32'(long_frame_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_fb_writer.md
# video_fb_writer

Pixel-stream sink on the far side of the display-source mux: consumes the muxed 16-bit RGB565 stream with its valid strobe and start-of-frame marker and turns it into linear write transactions for a single-port BRAM frame buffer. Captures one whole frame per arm request and flags short or overlong frames. Sits between the source mux and the frame-buffer BRAM, in the same clock domain as the mux.

## Interface
- `H_ACTIVE`, 320: pixels per input line.
- `V_ACTIVE`, 180: lines per input frame.
- `ADDR_W`, 16: BRAM address width; must satisfy 2^ADDR_W ≥ H_ACTIVE*V_ACTIVE.

- `clk_in` in 1: system clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `pixel_in` in 16: RGB565 pixel from the source mux.
- `valid_in` in 1: `pixel_in` valid this cycle.
- `sof_in` in 1: current pixel is first of a frame; meaningful only with `valid_in`.
- `arm_in` in 1: level; request capture of the next frame.
- `wr_en_out` out 1: BRAM write strobe.
- `wr_addr_out` out ADDR_W: BRAM write address.
- `wr_data_out` out 16: BRAM write data.
- `busy_out` out 1: high in ARMED or CAPTURE.
- `frame_done_out` out 1: one-cycle pulse after last pixel of a frame is written.
- `short_frame_out` out 1: sticky; `sof_in` arrived mid-capture.
- `long_frame_out` out 1: sticky; not raised in this build (see Configuration); reserved.

## Operation
- States: IDLE, ARMED, CAPTURE.
- IDLE: all input ignored. `arm_in`=1 → ARMED next cycle.
- ARMED: wait for `valid_in & sof_in`; that pixel is written at address 0 and state → CAPTURE with x=1, y=0 (x=0,y=1 if H_ACTIVE=1). Non-sof valid pixels ignored. `arm_in` falling in ARMED → IDLE.
- CAPTURE: each `valid_in` pixel written at current address; address += 1 per written pixel; x counts 0..H_ACTIVE-1, wraps to 0 and increments y.
- Completion: pixel with x=H_ACTIVE-1, y=V_ACTIVE-1 written → pulse `frame_done_out`, → ARMED if `arm_in`=1 that cycle, else IDLE.
- `sof_in` with `valid_in` in CAPTURE before completion: set `short_frame_out`, restart: pixel written at address 0, x=1, y=0, stay in CAPTURE; no `frame_done_out`.
- `valid_in` low: no write, counters hold; gaps of any length allowed.
- `arm_in` has no effect in CAPTURE; capture always runs to completion or restart.
- Sticky flags cleared only by `rst_in`.
- Address arithmetic: width ADDR_W, never wraps within a legal frame; final address H_ACTIVE*V_ACTIVE-1 (downsample build: (H_ACTIVE/2)*(V_ACTIVE/2)-1).

## Timing
- All outputs registered; write appears on `wr_*` one cycle after the accepted input beat.
- `frame_done_out` asserts in the same cycle as the last `wr_en_out`.
- Throughput: one pixel per cycle, sustained.
- Reset (async assert, sync deassert handled upstream): state IDLE, counters 0, `wr_en_out`=0, `wr_addr_out`=0, `wr_data_out`=0, `busy_out`=0, `frame_done_out`=0, both sticky flags 0.
- Reset mid-CAPTURE: in-flight write dropped, `wr_en_out` low immediately.

## Configuration
- `VIDEO_FB_WRITER_DOWNSAMPLE_EN` defined: 2x decimation; only pixels with even x and even y are written; address increments only on written pixels; frame buffer holds (H_ACTIVE/2)x(V_ACTIVE/2); completion and `frame_done_out` still keyed to input pixel x=H_ACTIVE-1, y=V_ACTIVE-1, so `frame_done_out` may fire with `wr_en_out`=0.
- Undefined: every accepted pixel written, full-resolution buffer.
- `long_frame_out` stays 0 in both builds.

## Structure
- Shared `video_pkg`: `pixel_t` (16-bit RGB565), `fbw_state_t` enum {IDLE, ARMED, CAPTURE}, default geometry constants H_ACTIVE/V_ACTIVE.
- One sub-module `fb_xy_counter`: x/y counters with enable, synchronous clear, and last-pixel flag; parameterized by H_ACTIVE/V_ACTIVE.
- FSM, address counter, output registers in top.

## Test plan
- Reset then `arm_in`=1, 320x180 frame, `valid_in` continuous, pixel = index → 57600 writes, addr 0..57599, data = index, one `frame_done_out` coincident with write 57599, then ARMED.
- ARMED, 10 valid non-sof pixels then sof → no writes for first 10; first write addr 0 with sof pixel data.
- `valid_in` toggling 1/0 every cycle through a frame → addresses contiguous, 57600 writes, completion ~115200 cycles after sof.
- sof reinjected after 1000 pixels → `short_frame_out`=1, next write at addr 0, no `frame_done_out` until 57600 further pixels.
- `rst_in` pulsed at pixel 500 → all outputs zero next edge, state IDLE, new frame without arm produces no writes.
- With `VIDEO_FB_WRITER_DOWNSAMPLE_EN`: full frame → 14400 writes, addr 0..14399, data from (x,y) even positions only, `frame_done_out` at input pixel (319,179) with `wr_en_out`=0.
